// File: rtl/CorePack.sv
// Shared core types: datapath word and ALU operation encoding.
package CorePack;

  typedef logic [63:0] data_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_enum;

endpackage

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand bypass and ALU operand selection.
// Bypass is applied at capture and re-applied every cycle while the stage is stalled,
// so results that retire during a stall still reach the held instruction.
module ex_operand_stage
  import CorePack::*;
#(
  parameter int unsigned XLEN      = $bits(data_t),
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [REG_IDX_W-1:0] in_rs1_idx,
  input  logic [REG_IDX_W-1:0] in_rs2_idx,
  input  logic [REG_IDX_W-1:0] in_rd_idx,
  input  logic                 in_we,
  input  alu_op_enum           in_alu_op,
  input  logic [1:0]           in_asel,
  input  logic                 in_bsel,
  input  logic                 flush,
  input  logic                 exm_we,
  input  logic [REG_IDX_W-1:0] exm_rd,
  input  logic [XLEN-1:0]      exm_data,
  input  logic                 mwb_we,
  input  logic [REG_IDX_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]      mwb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output alu_op_enum           alu_op,
  output logic [REG_IDX_W-1:0] out_rd_idx,
  output logic                 out_we,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_store_data
);

  logic                 valid_q, valid_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      rs1_q, rs1_d;
  logic [XLEN-1:0]      rs2_q, rs2_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic [REG_IDX_W-1:0] rs1_idx_q, rs1_idx_d;
  logic [REG_IDX_W-1:0] rs2_idx_q, rs2_idx_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 we_q, we_d;
  alu_op_enum           op_q, op_d;
  logic [1:0]           asel_q, asel_d;
  logic                 bsel_q, bsel_d;

  logic accept, fire;

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] bypass(
    input logic [REG_IDX_W-1:0] idx,
    input logic [XLEN-1:0]      dflt,
    input logic                 e_we,
    input logic [REG_IDX_W-1:0] e_rd,
    input logic [XLEN-1:0]      e_data,
    input logic                 m_we,
    input logic [REG_IDX_W-1:0] m_rd,
    input logic [XLEN-1:0]      m_data
  );
    if (idx == '0) begin
      return dflt;
    end else if (e_we && (e_rd == idx)) begin
      return e_data;
    end else if (m_we && (m_rd == idx)) begin
      return m_data;
    end
    return dflt;
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = valid_q && out_ready;

  // Next state: flush > accept > fire > hold (with stall bypass).
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    rd_d      = rd_q;
    we_d      = we_q;
    op_d      = op_q;
    asel_d    = asel_q;
    bsel_d    = bsel_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      rs1_d     = bypass(in_rs1_idx, in_rs1_data, exm_we, exm_rd, exm_data,
                         mwb_we, mwb_rd, mwb_data);
      rs2_d     = bypass(in_rs2_idx, in_rs2_data, exm_we, exm_rd, exm_data,
                         mwb_we, mwb_rd, mwb_data);
      imm_d     = in_imm;
      rs1_idx_d = in_rs1_idx;
      rs2_idx_d = in_rs2_idx;
      rd_d      = in_rd_idx;
      we_d      = in_we;
      op_d      = in_alu_op;
      asel_d    = in_asel;
      bsel_d    = in_bsel;
    end else if (fire) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      rs1_d = bypass(rs1_idx_q, rs1_q, exm_we, exm_rd, exm_data, mwb_we, mwb_rd, mwb_data);
      rs2_d = bypass(rs2_idx_q, rs2_q, exm_we, exm_rd, exm_data, mwb_we, mwb_rd, mwb_data);
    end
  end

  // Pipeline register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      op_q      <= ALU_ADD;
      asel_q    <= 2'd0;
      bsel_q    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      op_q      <= op_d;
      asel_q    <= asel_d;
      bsel_q    <= bsel_d;
    end
  end

  // Operand mux; reserved asel encoding yields zero.
  always_comb begin
    alu_a = '0;
    unique case (asel_q)
      2'd0:    alu_a = rs1_q;
      2'd1:    alu_a = pc_q;
      default: alu_a = '0;
    endcase
    alu_b = bsel_q ? imm_q : rs2_q;
  end

  assign out_valid      = valid_q;
  assign alu_op         = op_q;
  assign out_rd_idx     = rd_q;
  assign out_we         = we_q && valid_q;
  assign out_pc         = pc_q;
  assign out_store_data = rs2_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: vector table plus stall/flush/reset sequences,
// with a one-deep scoreboard of the instruction the stage should be presenting.
module tb_ex_operand_stage;
  import CorePack::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic        in_we;
  alu_op_enum  in_alu_op;
  logic [1:0]  in_asel;
  logic        in_bsel;
  logic        flush;
  logic        exm_we, mwb_we;
  logic [4:0]  exm_rd, mwb_rd;
  logic [63:0] exm_data, mwb_data;
  logic        out_valid, out_ready;
  logic [63:0] alu_a, alu_b, out_pc, out_store_data;
  alu_op_enum  alu_op;
  logic [4:0]  out_rd_idx;
  logic        out_we;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx), .in_we(in_we),
    .in_alu_op(in_alu_op), .in_asel(in_asel), .in_bsel(in_bsel), .flush(flush),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data), .mwb_we(mwb_we), .mwb_rd(mwb_rd),
    .mwb_data(mwb_data), .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .out_rd_idx(out_rd_idx), .out_we(out_we), .out_pc(out_pc),
    .out_store_data(out_store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1i, rs2i, rdi;
    logic        we;
    alu_op_enum  op;
    logic [1:0]  asel;
    logic        bsel;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    logic [63:0] ea, eb, es;
  } vec_t;

  typedef struct {
    logic [63:0] a, b, st, pc;
    logic [4:0]  rd;
    logic        we;
    alu_op_enum  op;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.a = v.ea; e.b = v.eb; e.st = v.es; e.pc = v.pc;
    e.rd = v.rdi; e.we = v.we; e.op = v.op;
    return e;
  endfunction

  task automatic drive_idle();
    in_valid = 0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1_idx = '0; in_rs2_idx = '0; in_rd_idx = '0; in_we = 0; in_alu_op = ALU_ADD;
    in_asel = '0; in_bsel = 0; flush = 0;
    exm_we = 0; exm_rd = '0; exm_data = '0; mwb_we = 0; mwb_rd = '0; mwb_data = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid = 1; in_pc = v.pc; in_rs1_data = v.rs1d; in_rs2_data = v.rs2d; in_imm = v.imm;
    in_rs1_idx = v.rs1i; in_rs2_idx = v.rs2i; in_rd_idx = v.rdi; in_we = v.we;
    in_alu_op = v.op; in_asel = v.asel; in_bsel = v.bsel;
    exm_we = v.e_we; exm_rd = v.e_rd; exm_data = v.e_data;
    mwb_we = v.m_we; mwb_rd = v.m_rd; mwb_data = v.m_data;
  endtask

  // Called after inputs are driven (mid low phase); checks in_ready, advances one edge and
  // updates the scoreboard from the bench's own view of accept/fire/flush.
  task automatic step(input string name, input exp_t e);
    bit mv, acc, fir;
    #1;
    mv  = (exp_q.size() != 0);
    chk({name, ".in_ready"}, 64'(in_ready), 64'(!mv || out_ready));
    fir = mv && out_ready;
    acc = in_valid && (!mv || out_ready) && !flush;
    @(posedge clk);
    if (fir || flush) exp_q.delete();
    if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic check_out(input string name);
    chk({name, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk({name, ".alu_a"}, alu_a, exp_q[0].a);
      chk({name, ".alu_b"}, alu_b, exp_q[0].b);
      chk({name, ".store"}, out_store_data, exp_q[0].st);
      chk({name, ".pc"}, out_pc, exp_q[0].pc);
      chk({name, ".rd"}, 64'(out_rd_idx), 64'(exp_q[0].rd));
      chk({name, ".we"}, 64'(out_we), 64'(exp_q[0].we));
      chk({name, ".op"}, 64'(alu_op), 64'(exp_q[0].op));
    end else begin
      chk({name, ".out_we"}, 64'(out_we), 64'd0);
    end
  endtask

  initial begin
    exp_t dummy;
    vec_t sv;
    dummy = '{a: '0, b: '0, st: '0, pc: '0, rd: '0, we: 0, op: ALU_ADD};
    //        pc       rs1d      rs2d     imm                    rs1i rs2i rd we op asel bsel
    //        e_we e_rd e_data   m_we m_rd m_data     ea        eb                     es
    vecs[0] = '{64'h100, 64'h5, 64'h22, 64'hFFFF_FFFF_FFFF_FFF0, 5'd1, 5'd2, 5'd10, 1, ALU_ADD,
                2'd0, 1, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0,
                64'h5, 64'hFFFF_FFFF_FFFF_FFF0, 64'h22};
    vecs[1] = '{64'h104, 64'h99, 64'h44, 64'h0, 5'd3, 5'd4, 5'd11, 1, ALU_SUB,
                2'd0, 0, 1, 5'd3, 64'h10, 1, 5'd3, 64'h20,
                64'h10, 64'h44, 64'h44};
    vecs[2] = '{64'h108, 64'h77, 64'h3, 64'h0, 5'd0, 5'd0, 5'd12, 0, ALU_XOR,
                2'd0, 0, 1, 5'd0, 64'h10, 1, 5'd0, 64'h20,
                64'h77, 64'h3, 64'h3};
    vecs[3] = '{64'h1000, 64'h8, 64'h1, 64'h0, 5'd2, 5'd9, 5'd13, 1, ALU_OR,
                2'd1, 0, 0, 5'd0, 64'h0, 1, 5'd9, 64'h55,
                64'h1000, 64'h55, 64'h55};
    vecs[4] = '{64'h110, 64'hAA, 64'hBB, 64'h0, 5'd5, 5'd6, 5'd14, 0, ALU_AND,
                2'd2, 0, 1, 5'd5, 64'hDEAD, 0, 5'd6, 64'hBEEF,
                64'h0, 64'hBB, 64'hBB};
    vecs[5] = '{64'h114, 64'hCC, 64'hDD, 64'h123, 5'd7, 5'd8, 5'd8, 1, ALU_SLL,
                2'd3, 1, 1, 5'd8, 64'hE0, 0, 5'd0, 64'h0,
                64'h0, 64'h123, 64'hE0};
    vecs[6] = '{64'h118, 64'h11, 64'h66, 64'h0, 5'd12, 5'd1, 5'd15, 1, ALU_SRA,
                2'd0, 0, 0, 5'd12, 64'hBAD, 1, 5'd12, 64'h600D,
                64'h600D, 64'h66, 64'h66};

    drive_idle();
    out_ready = 1;
    rst = 1;
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.alu_a", alu_a, 64'd0);
    chk("reset.alu_b", alu_b, 64'd0);
    chk("reset.alu_op", 64'(alu_op), 64'(ALU_ADD));
    chk("reset.out_we", 64'(out_we), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 0;

    // Back-to-back stream, out_ready held high.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      step($sformatf("vec%0d", i), to_exp(vecs[i]));
      check_out($sformatf("vec%0d", i));
    end
    @(negedge clk);
    drive_idle();
    step("drain", dummy);
    check_out("drain");

    // Stall with a MEM/WB result retiring mid-stall.
    sv = vecs[0];
    sv.rs2i = 5'd7; sv.rs2d = 64'h1111; sv.bsel = 0; sv.eb = 64'h1111; sv.es = 64'h1111;
    @(negedge clk);
    drive_vec(sv);
    step("stall.load", to_exp(sv));
    check_out("stall.load");
    @(negedge clk);
    drive_vec(vecs[1]);
    out_ready = 0;
    step("stall.c1", dummy);
    check_out("stall.c1");
    @(negedge clk);
    mwb_we = 1; mwb_rd = 5'd7; mwb_data = 64'hABCD;
    step("stall.c2", dummy);
    exp_q[0].b = 64'hABCD; exp_q[0].st = 64'hABCD;
    check_out("stall.c2");
    @(negedge clk);
    mwb_we = 0; mwb_data = 64'h0;
    step("stall.c3", dummy);
    check_out("stall.c3");

    // Flush while holding, with a new instruction offered.
    @(negedge clk);
    flush = 1;
    step("flush", dummy);
    check_out("flush");

    // Reset in the middle of a stall takes effect without a clock edge.
    @(negedge clk);
    drive_idle();
    out_ready = 1;
    drive_vec(vecs[3]);
    step("rst.load", to_exp(vecs[3]));
    check_out("rst.load");
    @(negedge clk);
    drive_idle();
    out_ready = 0;
    #2;
    rst = 1;
    #1;
    exp_q.delete();
    chk("rst.async.out_valid", 64'(out_valid), 64'd0);
    chk("rst.async.out_we", 64'(out_we), 64'd0);
    chk("rst.async.alu_a", alu_a, 64'd0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    step("post_rst", dummy);
    check_out("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that feeds the RV64 execute ALU.
- Captures one decoded instruction per handshake and resolves RAW hazards by bypassing from the EX/MEM and MEM/WB result buses, both at capture and every cycle while stalled.
- Drives the ALU operands a, b and alu_op directly.
- Also forwards rd, write enable, pc and store data to the downstream EX/MEM register.

Parameters:
- XLEN, 64, datapath width; equals CorePack::data_t width.
- REG_IDX_W, 5, register index width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction available.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  XLEN  instruction pc.
- in_rs1_data  input  XLEN  register-file read of rs1.
- in_rs2_data  input  XLEN  register-file read of rs2.
- in_imm  input  XLEN  sign-extended immediate.
- in_rs1_idx  input  REG_IDX_W  rs1 index.
- in_rs2_idx  input  REG_IDX_W  rs2 index.
- in_rd_idx  input  REG_IDX_W  destination index.
- in_we  input  1  instruction writes rd.
- in_alu_op  input  alu_op_enum  ALU operation.
- in_asel  input  2  a select: 0=rs1, 1=pc, 2=zero, 3=reserved (treated as zero).
- in_bsel  input  1  b select: 0=rs2, 1=imm.
- flush  input  1  kill held and incoming instruction.
- exm_we  input  1  EX/MEM result valid for writeback.
- exm_rd  input  REG_IDX_W  EX/MEM destination.
- exm_data  input  XLEN  EX/MEM result.
- mwb_we  input  1  MEM/WB result valid for writeback.
- mwb_rd  input  REG_IDX_W  MEM/WB destination.
- mwb_data  input  XLEN  MEM/WB result.
- out_valid  output  1  held instruction valid.
- out_ready  input  1  downstream accepts.
- alu_a  output  XLEN  ALU operand a.
- alu_b  output  XLEN  ALU operand b.
- alu_op  output  alu_op_enum  ALU operation.
- out_rd_idx  output  REG_IDX_W  destination.
- out_we  output  1  writes rd, gated by out_valid.
- out_pc  output  XLEN  pc.
- out_store_data  output  XLEN  bypassed rs2 value, regardless of bsel.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0.
  - All held fields zero; held alu_op=ALU_ADD, so alu_a=alu_b=0 and out_we=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
  - Accept when in_valid && in_ready.
  - Fire (downstream transfer) when out_valid && out_ready.
- Latency: 1 cycle. An instruction accepted at edge N is presented after edge N with out_valid=1.
- Next state at each edge, in priority order:
  - flush=1 → out_valid=0 and incoming data discarded (accept ignored).
  - accept → load fields, out_valid=1.
  - fire without accept → out_valid=0.
  - otherwise hold.
- Bypass at capture, per source s in {rs1, rs2}:
  - If exm_we && exm_rd==idx_s && idx_s!=0, take exm_data.
  - Else if mwb_we && mwb_rd==idx_s && idx_s!=0, take mwb_data.
  - Else take in_*_data.
  - EX/MEM has priority over MEM/WB.
- Bypass while held (out_valid && !fire && !flush): the held rs1/rs2 values are rewritten each cycle using the same matching rules against the held indices. Results retired during a stall are therefore captured.
- Index 0 is never bypassed; rs value for x0 is whatever the register file supplied (0).
- Operand mux (combinational from held regs):
  - alu_a = rs1 / pc / 0 per asel.
  - alu_b = rs2 / imm per bsel.
- out_we = held_we && out_valid.
- Simultaneous fire and accept: new instruction replaces old in the same edge; no bubble.
- flush together with fire: downstream still sees the fire this cycle; the stage becomes empty.
- Reset mid-stall: immediately empty; no residual bypass state.

Test Plan:
- Reset then idle → out_valid=0, alu_a=0, alu_b=0, alu_op=ALU_ADD, in_ready=1.
- Accept rs1_data=5, imm=0xFFFF_FFFF_FFFF_FFF0, asel=0, bsel=1, alu_op=ALU_ADD → next cycle out_valid=1, alu_a=5, alu_b=0xFFFF_FFFF_FFFF_FFF0.
- Capture with rs1_idx=3, exm_we=1, exm_rd=3, exm_data=0x10, mwb_we=1, mwb_rd=3, mwb_data=0x20 → alu_a=0x10. Repeat with idx=0 → alu_a=in_rs1_data.
- Hold with out_ready=0 for 3 cycles, rs2_idx=7, bsel=0; in cycle 2 pulse mwb_we=1, mwb_rd=7, mwb_data=0xABCD → from cycle 3 alu_b=out_store_data=0xABCD; in_ready=0 throughout.
- Back-to-back accept with out_ready=1 every cycle, 4 instructions → out_valid stays 1, each presented exactly one cycle in order.
- flush asserted with in_valid=1 while holding → next cycle out_valid=0, out_we=0. Assert rst mid-hold → out_valid=0 immediately, without waiting for a clock edge.
